// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte (start, 8 data bits LSB first, odd parity, stop) to the device and checks
// its acknowledge bit. PS2_CLK/PS2_DAT are driven open-drain through the *_oe_o outputs.
// Optional feature: define PS2_TX_TIMEOUT_EN to enable a watchdog that aborts a stalled frame.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       send_i,
    input  logic [7:0] tx_data_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StXfer,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic            parity_q, parity_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            clk_prev_q;
    logic            clk_s, dat_s, clk_fall;
    logic            active, timeout, xfer_bit;

    assign clk_s    = clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_s;
    assign active   = (state_q == StReq) || (state_q == StXfer) ||
                      (state_q == StAck) || (state_q == StWaitIdle);

    // Two-flop synchronisers for the asynchronous line levels; idle-high after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
        end
    end

    // Previous synced clock; held low in IDLE/INHIBIT so edge detection restarts at REQ entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_prev_q <= 1'b0;
        end else if ((state_q == StIdle) || (state_q == StInhibit)) begin
            clk_prev_q <= 1'b0;
        end else begin
            clk_prev_q <= clk_s;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_q;

    // Watchdog: held clear until REQ entry, restarted by every device falling edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q <= '0;
        end else if (!active || clk_fall) begin
            wd_q <= '0;
        end else if (wd_q != WdLast) begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign timeout = active && (wd_q == WdLast);
`else
    assign timeout = 1'b0;
`endif

    // Bit currently presented during XFER: data LSB first, then parity, then stop (released).
    always_comb begin
        xfer_bit = 1'b1;
        if ((bit_cnt_q >= 4'd1) && (bit_cnt_q <= 4'd8)) begin
            xfer_bit = data_q[3'(bit_cnt_q - 4'd1)];
        end else if (bit_cnt_q == 4'd9) begin
            xfer_bit = parity_q;
        end
    end

    // FSM state and frame registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            data_q    <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state logic and line drive decode.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        parity_d     = parity_q;
        bit_cnt_d    = bit_cnt_q;
        inh_cnt_d    = inh_cnt_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        ps2_clk_oe_o = 1'b0;
        ps2_dat_oe_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (send_i && !busy_o) begin
                    data_d    = tx_data_i;
                    parity_d  = ~^tx_data_i;
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                ps2_clk_oe_o = 1'b1;
                // Data goes low while clock is still held: request-to-send.
                ps2_dat_oe_o = (inh_cnt_q == InhLast);
                if (inh_cnt_q == InhLast) begin
                    state_d = StReq;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            StReq: begin
                ps2_dat_oe_o = 1'b1;
                if (clk_fall) begin
                    bit_cnt_d = 4'd1;
                    state_d   = StXfer;
                end
            end
            StXfer: begin
                ps2_dat_oe_o = ~xfer_bit;
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                if (clk_fall) begin
                    if (!dat_s) begin
                        state_d = StWaitIdle;
                    end else begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitIdle: begin
                if (clk_s && dat_s) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (timeout) begin
            ps2_clk_oe_o = 1'b0;
            ps2_dat_oe_o = 1'b0;
            done_d       = 1'b0;
            error_d      = 1'b1;
            state_d      = StIdle;
        end
    end

    assign busy_o  = (state_q != StIdle) || done_q || error_q;
    assign done_o  = done_q;
    assign error_o = error_q;

endmodule
